// File: rtl/loopback_pattern_gen.sv
// loopback_pattern_gen: framed test-data source for the loopback path.
// Patterns are counter, PRBS-7, walking-one or constant. The first beat
// is valid one cycle after an accepted start.
// Backpressure: when m_tready is low, m_tdata and m_tlast hold and the
// pattern does not advance.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, stop       run control pulses (start ignored while busy)
//   mode              00 counter, 01 PRBS-7, 10 walking-one, 11 constant
//   frame_len         beats per frame (0 treated as 1)
//   num_frames        frames per run (0 = until stop)
//   m_tdata/m_tvalid/m_tready/m_tlast   stream master
//   busy, done, frame_cnt               run status
//   err_inject        present only when LBPG_ERR_INJECT_EN is defined;
//                     flips bit 0 of the next transferred beat
module loopback_pattern_gen #(
   parameter int                DATA_W     = 8,
   parameter int                IFG_CYCLES = 2,
   parameter logic [DATA_W-1:0] CONST_PAT  = DATA_W'(8'hA5)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [15:0]       frame_len,
   input  logic [15:0]       num_frames,
`ifdef LBPG_ERR_INJECT_EN
   input  logic              err_inject,
`endif
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              busy,
   output logic              done,
   output logic [15:0]       frame_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

   localparam logic [15:0] GAP_LOAD = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

   state_t            state, state_nxt;
   logic [1:0]        mode_q;
   logic [15:0]       len_q, nfr_q;
   logic [15:0]       beat_cnt;
   logic [15:0]       frame_cnt_q;
   logic [15:0]       gap_cnt;
   logic [DATA_W-1:0] pat;
   logic              stop_pend;

   logic              xfer;
   logic              is_last;
   logic [15:0]       len_last;
   logic [15:0]       frame_cnt_inc;
   logic              end_run;
   logic              stop_seen;
   logic              inj_bit;

   // First-beat value of each pattern.
   function automatic logic [DATA_W-1:0] pat_seed(input logic [1:0] m);
      logic [DATA_W-1:0] s;
      case (m)
         2'b00:   s = '0;
         2'b01:   s = DATA_W'(7'h7F);
         2'b10:   s = DATA_W'(1);
         default: s = CONST_PAT;
      endcase
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] p);
      logic [DATA_W-1:0] n;
      case (m)
         2'b00:   n = p + DATA_W'(1);
         2'b01:   n = {{(DATA_W-7){1'b0}}, p[5:0], p[6] ^ p[5]};
         2'b10:   n = {p[DATA_W-2:0], p[DATA_W-1]};
         default: n = p;
      endcase
      return n;
   endfunction

   assign xfer          = m_tvalid & m_tready;
   // frame_len of 0 behaves as a single-beat frame.
   assign len_last      = (len_q == 16'd0) ? 16'd0 : len_q - 16'd1;
   assign is_last       = (beat_cnt == len_last);
   assign frame_cnt_inc = frame_cnt_q + 16'd1;
   // A stop arriving on the same cycle as the last beat still ends the run.
   assign stop_seen     = stop_pend | stop;
   assign end_run       = stop_seen | ((nfr_q != 16'd0) && (frame_cnt_inc == nfr_q));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            if (xfer && is_last) begin
               if (end_run)              state_nxt = FIN;
               else if (IFG_CYCLES > 0)  state_nxt = GAP;
               else                      state_nxt = RUN;
            end
         end
         GAP: if (gap_cnt == 16'd0) state_nxt = stop_seen ? FIN : RUN;
         FIN: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mode_q      <= 2'b00;
         len_q       <= 16'd0;
         nfr_q       <= 16'd0;
         beat_cnt    <= 16'd0;
         frame_cnt_q <= 16'd0;
         gap_cnt     <= 16'd0;
         pat         <= pat_seed(2'b00);
         stop_pend   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q      <= mode;
                  len_q       <= frame_len;
                  nfr_q       <= num_frames;
                  frame_cnt_q <= 16'd0;
                  beat_cnt    <= 16'd0;
                  pat         <= pat_seed(mode);
               end
            end
            RUN: begin
               if (xfer) begin
                  if (is_last) begin
                     // Reload the seed now so the next frame starts clean
                     // whether or not a gap follows.
                     beat_cnt    <= 16'd0;
                     pat         <= pat_seed(mode_q);
                     frame_cnt_q <= frame_cnt_inc;
                     gap_cnt     <= GAP_LOAD;
                  end else begin
                     beat_cnt <= beat_cnt + 16'd1;
                     pat      <= pat_next(mode_q, pat);
                  end
               end
            end
            GAP: if (gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
            default: ;
         endcase

         if (state == FIN)
            stop_pend <= 1'b0;
         else if (state != IDLE && stop)
            stop_pend <= 1'b1;
      end
   end

`ifdef LBPG_ERR_INJECT_EN
   // err_act corrupts the beat currently presented; err_pend holds a request
   // that arrived during a stall so the stalled beat is never altered.
   logic err_act, err_pend;
   logic stalled;

   assign stalled = m_tvalid & ~m_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_act  <= 1'b0;
         err_pend <= 1'b0;
      end else if (xfer && err_act) begin
         err_act  <= 1'b0;
         err_pend <= 1'b0;
      end else if (!err_act && (err_pend || err_inject)) begin
         if (stalled) begin
            err_pend <= 1'b1;
         end else begin
            err_act  <= 1'b1;
            err_pend <= 1'b0;
         end
      end
   end

   assign inj_bit = err_act;
`else
   assign inj_bit = 1'b0;
`endif

   assign m_tvalid  = (state == RUN);
   assign m_tlast   = (state == RUN) && is_last;
   assign m_tdata   = (state == RUN) ? (pat ^ DATA_W'(inj_bit)) : '0;
   assign busy      = (state == RUN) || (state == GAP);
   assign done      = (state == FIN);
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_loopback_pattern_gen.sv
module tb_loopback_pattern_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop;
   logic [1:0]  mode;
   logic [15:0] frame_len, num_frames;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic        busy, done;
   logic [15:0] frame_cnt;
`ifdef LBPG_ERR_INJECT_EN
   logic        err_inject = 1'b0;
`endif

   loopback_pattern_gen #(.DATA_W(8), .IFG_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .frame_len(frame_len), .num_frames(num_frames),
`ifdef LBPG_ERR_INJECT_EN
      .err_inject(err_inject),
`endif
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .busy(busy), .done(done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q[$];          // {last, data}
   int         xfer_cnt = 0;
   int         last_xfer_cyc = -1;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_dat;
   logic       prev_last;

   localparam logic [7:0] PRBS_TAB [8] = '{8'h7F, 8'h7E, 8'h7C, 8'h78,
                                           8'h70, 8'h60, 8'h40, 8'h01};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: pops one expectation per transferred beat.
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_data_stable", m_tdata, prev_dat);
            chk("stall_last_stable", m_tlast, prev_last);
         end
         if (m_tvalid && m_tready) begin
            xfer_cnt++;
            if (m_tlast) last_xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_underflow: got beat %0h, expected none", m_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_tdata, e[7:0]);
               chk("beat_last", m_tlast, e[8]);
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_dat   = m_tdata;
         prev_last  = m_tlast;
      end
   end

   task automatic push_frame(input logic [1:0] m, input int len);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         case (m)
            2'b00:   d = i[7:0];
            2'b01:   d = PRBS_TAB[i % 8];
            2'b10:   d = 8'd1 << (i % 8);
            default: d = 8'hA5;
         endcase
         exp_q.push_back({(i == len - 1), d});
      end
   endtask

   // Leaves the bench 1 ns after the edge on which the start was accepted.
   task automatic do_start(input logic [1:0] m, input logic [15:0] len, input logic [15:0] n);
      @(posedge clk); #1;
      mode = m; frame_len = len; num_frames = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mode = ~m; frame_len = 16'd3; num_frames = 16'd7;
      chk("first_valid_latency", m_tvalid, 1);
      chk("busy_after_start", busy, 1);
      chk("frame_cnt_cleared", frame_cnt, 0);
   endtask

   task automatic wait_done(input int exp_fc, input bit rnd_ready);
      bit seen = 0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(posedge clk); #1;
         if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (done) seen = 1;
      end
      m_tready = 1'b1;
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done, expected done within 5000 cycles");
      end else begin
         chk("done_busy_low", busy, 0);
         chk("done_valid_low", m_tvalid, 0);
         chk("frame_cnt_at_done", frame_cnt, exp_fc);
         chk("done_one_after_last", cyc - last_xfer_cyc, 1);
         chk("scoreboard_drained", exp_q.size(), 0);
         @(negedge clk);
         chk("done_single_pulse", done, 0);
         chk("frame_cnt_holds", frame_cnt, exp_fc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int g;
      bit seen;

      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
      frame_len = 16'd0; num_frames = 16'd0; m_tready = 1'b1;
      #12;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      @(posedge clk); #2;
      rst = 1'b0;

      // Counter, 300 beats: wraps 00..FF then 00..2B.
      push_frame(2'b00, 300);
      do_start(2'b00, 16'd300, 16'd1);
      wait_done(1, 0);

      // A stop in IDLE must not leak into the next run.
      @(posedge clk); #1; stop = 1'b1;
      @(posedge clk); #1; stop = 1'b0;

      // PRBS, two frames of 8 with a 2-cycle gap; a start while busy is ignored.
      push_frame(2'b01, 8);
      push_frame(2'b01, 8);
      do_start(2'b01, 16'd8, 16'd2);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (m_tvalid && m_tready && m_tlast) seen = 1;
      end
      g = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m_tvalid) break;
         g++;
      end
      chk("ifg_idle_cycles", g, 2);
      wait_done(2, 0);

      // Walking-one, frame_len 10, random backpressure.
      push_frame(2'b10, 10);
      do_start(2'b10, 16'd10, 16'd1);
      wait_done(1, 1);

      // Constant, endless frames; stop at beat 3 of frame 5.
      for (int f = 0; f < 5; f++) push_frame(2'b11, 16);
      base = xfer_cnt;
      do_start(2'b11, 16'd16, 16'd0);
      seen = 0;
      for (int i = 0; i < 500 && !seen; i++) begin
         if (xfer_cnt == base + 67) seen = 1;
         else begin @(posedge clk); #1; end
      end
      chk("stop_point_reached", seen, 1);
      stop = 1'b1;
      @(posedge clk); #1; stop = 1'b0;
      wait_done(5, 0);

      // Asynchronous reset mid-frame, then a fresh run.
      push_frame(2'b00, 50);
      do_start(2'b00, 16'd50, 16'd1);
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_tvalid", m_tvalid, 0);
      chk("midrst_tdata", m_tdata, 0);
      chk("midrst_tlast", m_tlast, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      exp_q.delete();
      @(posedge clk); #2 rst = 1'b0;
      push_frame(2'b00, 4);
      do_start(2'b00, 16'd4, 16'd1);
      wait_done(1, 0);

`ifdef LBPG_ERR_INJECT_EN
      // Inject while beat 3 is presented: only beat 4 has bit 0 flipped.
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h02});
      exp_q.push_back({1'b0, 8'h03});
      exp_q.push_back({1'b0, 8'h05});
      exp_q.push_back({1'b0, 8'h05});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b1, 8'h07});
      do_start(2'b00, 16'd8, 16'd1);
      repeat (3) begin @(posedge clk); #1; end
      err_inject = 1'b1;
      @(posedge clk); #1; err_inject = 1'b0;
      wait_done(1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/loopback_pattern_gen.md
Name: loopback_pattern_gen

Overview:
Parametrised test-data source for the loopback path, and the successor to the free-running 8-bit counter source. Emits framed data on an AXI-Stream-style valid/ready master port. Runtime-selectable pattern: counter, PRBS-7, walking-one or constant. Supports programmable frame length, frame count, inter-frame gap and graceful stop, so the loopback checker can align on frames and compare data.

Parameters:
DATA_W, 8, data bus width in bits; legal range 8..64.
IFG_CYCLES, 2, idle cycles between frames with m_tvalid low; 0 means back-to-back frames.
CONST_PAT, 8'hA5, constant-mode pattern, zero-extended to DATA_W.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  single-cycle start pulse; ignored while busy=1
stop  in  1  pulse; finish the current frame, then go idle
mode  in  2  00 counter, 01 PRBS-7, 10 walking-one, 11 constant; sampled on an accepted start
frame_len  in  16  beats per frame, sampled on start; 0 is treated as 1
num_frames  in  16  frames to send, sampled on start; 0 means run until stop
m_tdata  out  DATA_W  pattern data
m_tvalid  out  1  data valid
m_tready  in  1  downstream ready
m_tlast  out  1  last beat of the frame
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the run ends
frame_cnt  out  16  frames completed in the current run; wraps at 16'hFFFF

Behaviour:
- Reset (async, immediate, including mid-frame): state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, frame_cnt=0, beat counter=0, pattern register=seed. No partial frame resumes after reset.
- FSM states: IDLE, RUN, GAP, FIN.
- IDLE -> RUN on start. Latch mode, frame_len and num_frames. Clear frame_cnt. busy=1 and m_tvalid=1 from the next cycle. Latency from start to first valid beat is 1 cycle.
- RUN: a beat is transferred when m_tvalid && m_tready. While m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
- m_tlast=1 exactly on beat index frame_len-1.
- On the transfer of the last beat: frame_cnt+1, then:
  - if the stop is pending, or num_frames!=0 and the new frame_cnt==num_frames, go to FIN;
  - else if IFG_CYCLES>0, go to GAP;
  - else stay in RUN and start the next frame on the next cycle.
- GAP: m_tvalid=0 for exactly IFG_CYCLES cycles, then RUN.
- FIN: m_tvalid=0, done=1 for one cycle, busy=0 in the same cycle; next state IDLE.
- stop: latched as pending in any non-IDLE state; never truncates a frame. A stop in GAP goes to FIN at the end of the gap. Stop in IDLE is ignored. Pending stop clears on entry to IDLE.
- Simultaneous start and stop in IDLE: start is taken, stop is ignored.
- Patterns restart at frame start (beat 0); the pattern advances only on a transfer:
  - Counter: beat 0 = 0, then +1, wrapping from 2^DATA_W-1 to 0 within a frame.
  - PRBS-7: seed 7'h7F. next = {p[5:0], p[6]^p[5]}. m_tdata = p zero-extended. Sequence: 7F,7E,7C,78,70,60,40,01,...; period 127.
  - Walking-one: beat 0 = 1, rotate left by 1 per beat, wrapping bit DATA_W-1 back to bit 0.
  - Constant: CONST_PAT on every beat.
- frame_cnt holds its value after done until the next start.

Optional Feature:
LBPG_ERR_INJECT_EN
- Defined: adds input port err_inject (1 bit). A pulse arms a single-shot flag. The next transferred beat has m_tdata[0] inverted; the internal pattern state is not altered, so following beats are correct. The flag clears on that transfer or on reset. Further pulses while armed are absorbed.
- Undefined: port absent, no injection logic; m_tdata is always the pure pattern.

Test Plan:
- Counter, DATA_W=8, frame_len=300, num_frames=1, m_tready=1: beats 00..FF then 00..2B; m_tlast only on beat 299; done pulses 1 cycle after it; frame_cnt=1.
- PRBS, frame_len=8, num_frames=2, IFG_CYCLES=2: each frame is 7F,7E,7C,78,70,60,40,01; exactly 2 cycles of m_tvalid=0 between frames; frame_cnt=2 at done.
- Backpressure in walking-one mode with m_tready toggled randomly, frame_len=10: m_tdata and m_tlast stable while stalled; sequence 01,02,04,...,80,01,02.
- num_frames=0, constant mode, stop pulsed at beat 3 of frame 5 (frame_len=16): frame 5 completes all 16 beats of A5, then done; frame_cnt=5.
- Async rst asserted mid-frame: all outputs 0 immediately; a subsequent start begins a fresh frame at beat 0 with frame_cnt=0. A start pulsed while busy has no effect.
- LBPG_ERR_INJECT_EN defined, counter mode, err_inject pulsed before beat 4: beat 4 = 05, beats 3 and 5 = 03 and 05 uncorrupted, i.e. only beat 4 flipped.
